// File: rtl/fb_mem_arbiter_if.sv
// rtl/fb_mem_arbiter_if.sv - requester handshakes and RAM pins of fb_mem_arbiter
//
// Purpose: bundles the VGA read port, the UART write port and the cellular
// RAM pins into one interface.
//   slave  modport : arbiter side (takes requests and mem_din, drives acks,
//                    read data and all RAM controls)
//   master modport : requester/pin side (the opposite directions)
// Signals:
//   rd_req/rd_addr -> rd_ack, rd_data, rd_valid        read port
//   wr_req/wr_addr/wr_data/wr_be -> wr_ack              write port
//   mem_addr, mem_dout, mem_dq_oe, mem_*_n -> RAM      mem_din <- RAM
interface fb_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            wr_be;
  logic                  wr_ack;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_dq_oe;
  logic                  mem_cs_n;
  logic                  mem_oe_n;
  logic                  mem_we_n;
  logic                  mem_lb_n;
  logic                  mem_ub_n;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, mem_din,
    output rd_ack, rd_data, rd_valid, wr_ack,
    output mem_addr, mem_dout, mem_dq_oe, mem_cs_n, mem_oe_n, mem_we_n,
    output mem_lb_n, mem_ub_n
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, mem_din,
    input  rd_ack, rd_data, rd_valid, wr_ack,
    input  mem_addr, mem_dout, mem_dq_oe, mem_cs_n, mem_oe_n, mem_we_n,
    input  mem_lb_n, mem_ub_n
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - VGA-read / UART-write arbiter for async cellular RAM
//
// Purpose: grants one access at a time to the shared RAM and sequences it
// with clock-counted timing. Read: RD (ACCESS_CYCLES) -> RECOV -> IDLE.
// Write: WR (ACCESS_CYCLES) -> WHOLD -> IDLE. Every access spends
// ACCESS_CYCLES+2 clocks from IDLE back to IDLE. All outputs are registered.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; aborts any access in flight
//   bus    fb_mem_arbiter_if.slave (read port, write port, RAM pins)
// Optional feature macro: FB_ARB_STARVE_GUARD_EN
//   defined   : after MAX_RD_STREAK reads granted while a write waits, the
//               write is granted next even if a read is pending
//   undefined : strict read priority
module fb_mem_arbiter #(
  parameter int ADDR_WIDTH    = 23,
  parameter int DATA_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 4
`ifdef FB_ARB_STARVE_GUARD_EN
  ,
  parameter int MAX_RD_STREAK = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  fb_mem_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_WHOLD,
    S_RECOV
  } state_t;

  // Counter runs ACCESS_CYCLES-1 down to 0, so the strobe lasts ACCESS_CYCLES.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  cs_n_q, cs_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  lb_n_q, lb_n_d;
  logic                  ub_n_q, ub_n_d;
  logic                  dq_oe_q, dq_oe_d;

  logic                  grant_rd;
  logic                  grant_wr;
  logic                  force_wr;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_RD_STREAK + 1);

  logic [SW-1:0] streak_q, streak_d;

  // Streak saturates here: a waiting write is forced through next.
  assign force_wr = bus.wr_req && (streak_q == SW'(MAX_RD_STREAK));

  always_comb begin
    streak_d = streak_q;
    if (grant_wr) begin
      streak_d = '0;
    end else if (grant_rd) begin
      streak_d = bus.wr_req ? streak_q + SW'(1) : '0;
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  // Requests are only looked at in IDLE; read wins unless the guard forces.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.rd_req && !force_wr) begin
        grant_rd = 1'b1;
      end else if (bus.wr_req) begin
        grant_wr = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rd_data_d  = rd_data_q;
    rd_ack_d   = 1'b0;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    cs_n_d     = cs_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    lb_n_d     = lb_n_q;
    ub_n_d     = ub_n_q;
    dq_oe_d    = dq_oe_q;

    case (state_q)
      S_IDLE: begin
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (grant_rd) begin
          state_d  = S_RD;
          cnt_d    = CNT_LOAD;
          addr_d   = bus.rd_addr;
          rd_ack_d = 1'b1;
          cs_n_d   = 1'b0;
          oe_n_d   = 1'b0;
          lb_n_d   = 1'b0;
          ub_n_d   = 1'b0;
        end else if (grant_wr) begin
          state_d  = S_WR;
          cnt_d    = CNT_LOAD;
          addr_d   = bus.wr_addr;
          dout_d   = bus.wr_data;
          wr_ack_d = 1'b1;
          cs_n_d   = 1'b0;
          we_n_d   = 1'b0;
          lb_n_d   = ~bus.wr_be[0];
          ub_n_d   = ~bus.wr_be[1];
          dq_oe_d  = 1'b1;
        end
      end

      S_RD: begin
        if (cnt_q == 4'd0) begin
          // Data sampled at the edge closing the last OE cycle.
          state_d    = S_RECOV;
          rd_data_d  = bus.mem_din;
          rd_valid_d = 1'b1;
          cs_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          lb_n_d     = 1'b1;
          ub_n_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_WR: begin
        if (cnt_q == 4'd0) begin
          // WE rises first; CS, address and data stay put for hold time.
          state_d = S_WHOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_WHOLD: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end

      S_RECOV: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      dout_q     <= '0;
      rd_data_q  <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
`ifdef FB_ARB_STARVE_GUARD_EN
      streak_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      cs_n_q     <= cs_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      lb_n_q     <= lb_n_d;
      ub_n_q     <= ub_n_d;
      dq_oe_q    <= dq_oe_d;
`ifdef FB_ARB_STARVE_GUARD_EN
      streak_q   <= streak_d;
`endif
    end
  end

  assign bus.rd_ack    = rd_ack_q;
  assign bus.wr_ack    = wr_ack_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_dout  = dout_q;
  assign bus.mem_dq_oe = dq_oe_q;
  assign bus.mem_cs_n  = cs_n_q;
  assign bus.mem_oe_n  = oe_n_q;
  assign bus.mem_we_n  = we_n_q;
  assign bus.mem_lb_n  = lb_n_q;
  assign bus.mem_ub_n  = ub_n_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb/tb_fb_mem_arbiter.sv - directed self-checking bench for fb_mem_arbiter
module tb_fb_mem_arbiter;

  localparam int AW = 23;
  localparam int DW = 16;

  // {cs_n, oe_n, we_n, lb_n, ub_n, dq_oe, rd_ack, wr_ack, rd_valid}
  localparam logic [8:0] C_IDLE   = 9'b11111_0_000;
  localparam logic [8:0] C_RD_ACK = 9'b00100_0_100;
  localparam logic [8:0] C_RD     = 9'b00100_0_000;
  localparam logic [8:0] C_RECOV  = 9'b11111_0_001;
  localparam logic [8:0] C_WR1_AK = 9'b01001_1_010;
  localparam logic [8:0] C_WR1    = 9'b01001_1_000;
  localparam logic [8:0] C_WH1    = 9'b01101_1_000;
  localparam logic [8:0] C_WR0_AK = 9'b01011_1_010;
  localparam logic [8:0] C_WR3_AK = 9'b01000_1_010;
  localparam logic [8:0] C_WR3    = 9'b01000_1_000;

  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nerr = 0;
  bit   run  = 1'b0;

  fb_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fb_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .ACCESS_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ctrl();
    return {bus.mem_cs_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_lb_n, bus.mem_ub_n,
            bus.mem_dq_oe, bus.rd_ack, bus.wr_ack, bus.rd_valid};
  endfunction

  // Bus-safety checker, active for the whole run.
  always @(negedge clk) begin
    if (run) begin
      ncmp++;
      assert (!(bus.mem_oe_n === 1'b0 && bus.mem_dq_oe === 1'b1)) else begin
        nerr++;
        $error("FAIL oe_vs_dq_oe: observed oe_n=%b dq_oe=%b expected not 0/1", bus.mem_oe_n, bus.mem_dq_oe);
      end
      ncmp++;
      assert (!(bus.mem_oe_n === 1'b0 && bus.mem_we_n === 1'b0)) else begin
        nerr++;
        $error("FAIL oe_vs_we: observed oe_n=%b we_n=%b expected not both 0", bus.mem_oe_n, bus.mem_we_n);
      end
    end
  end

  initial begin
    int nrd;
    int nwr;
    int first_wr;

    reset       = 1'b1;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_be   = 2'b00;
    bus.mem_din = '0;
    tick();
    tick();
    tick();
    run = 1'b1;

    // Reset state
    chk("reset_ctrl", 32'(ctrl()), 32'(C_IDLE));
    chk("reset_addr", 32'(bus.mem_addr), 32'h0);
    chk("reset_dout", 32'(bus.mem_dout), 32'h0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'h0);
    reset = 1'b0;

    // Idle with no requests for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_ctrl", 32'(ctrl()), 32'(C_IDLE));
    end

    // Single read: addr 0x00123, RAM returns 0xBEEF
    bus.rd_req  = 1'b1;
    bus.rd_addr = 23'h00123;
    bus.mem_din = 16'hBEEF;
    tick();
    chk("rd_t1_ctrl", 32'(ctrl()), 32'(C_RD_ACK));
    chk("rd_t1_addr", 32'(bus.mem_addr), 32'h00123);
    bus.rd_req = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("rd_strobe_ctrl", 32'(ctrl()), 32'(C_RD));
    end
    tick();
    chk("rd_t5_ctrl", 32'(ctrl()), 32'(C_RECOV));
    chk("rd_t5_data", 32'(bus.rd_data), 32'hBEEF);
    tick();
    chk("rd_t6_ctrl", 32'(ctrl()), 32'(C_IDLE));

    // Write: addr 0x4000, data 0x00A5, low byte only
    bus.wr_req  = 1'b1;
    bus.wr_addr = 23'h04000;
    bus.wr_data = 16'h00A5;
    bus.wr_be   = 2'b01;
    tick();
    chk("wr_t1_ctrl", 32'(ctrl()), 32'(C_WR1_AK));
    chk("wr_t1_addr", 32'(bus.mem_addr), 32'h04000);
    chk("wr_t1_dout", 32'(bus.mem_dout), 32'h00A5);
    bus.wr_req  = 1'b0;
    bus.wr_data = 16'hFFFF;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("wr_strobe_ctrl", 32'(ctrl()), 32'(C_WR1));
      chk("wr_strobe_dout", 32'(bus.mem_dout), 32'h00A5);
    end
    tick();
    chk("wr_hold_ctrl", 32'(ctrl()), 32'(C_WH1));
    chk("wr_hold_dout", 32'(bus.mem_dout), 32'h00A5);
    chk("wr_hold_addr", 32'(bus.mem_addr), 32'h04000);
    tick();
    chk("wr_t6_ctrl", 32'(ctrl()), 32'(C_IDLE));

    // Write with no byte enables is still a full, acked cycle
    bus.wr_req = 1'b1;
    bus.wr_be  = 2'b00;
    tick();
    chk("wr_be0_t1_ctrl", 32'(ctrl()), 32'(C_WR0_AK));
    bus.wr_req = 1'b0;
    for (int i = 2; i <= 6; i++) tick();
    chk("wr_be0_t6_ctrl", 32'(ctrl()), 32'(C_IDLE));

    // Write request dropped before any IDLE sees it is not serviced
    bus.rd_req  = 1'b1;
    bus.rd_addr = 23'h00007;
    tick();
    chk("drop_rd_ack", 32'(ctrl()), 32'(C_RD_ACK));
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    nwr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.wr_ack === 1'b1) nwr++;
    end
    chk("drop_wr_acks", 32'(nwr), 32'd0);
    chk("drop_end_ctrl", 32'(ctrl()), 32'(C_IDLE));

    // Both requests held for 120 cycles
    bus.rd_req  = 1'b1;
    bus.rd_addr = 23'h00055;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 23'h00066;
    bus.wr_data = 16'h1234;
    bus.wr_be   = 2'b11;
    nrd = 0;
    nwr = 0;
    first_wr = 0;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (bus.rd_ack === 1'b1) nrd++;
      if (bus.wr_ack === 1'b1) begin
        nwr++;
        if (first_wr == 0) first_wr = i;
      end
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
`ifdef FB_ARB_STARVE_GUARD_EN
    chk("both_rd_grants", 32'(nrd), 32'd18);
    chk("both_wr_grants", 32'(nwr), 32'd2);
    chk("both_first_wr_cycle", 32'(first_wr), 32'd49);
`else
    chk("both_rd_grants", 32'(nrd), 32'd20);
    chk("both_wr_grants", 32'(nwr), 32'd0);
    chk("both_first_wr_cycle", 32'(first_wr), 32'd0);
`endif
    for (int i = 0; i < 8; i++) tick();
    chk("both_drain_ctrl", 32'(ctrl()), 32'(C_IDLE));

    // Reset in the second WR cycle aborts the access
    bus.wr_req  = 1'b1;
    bus.wr_addr = 23'h01234;
    bus.wr_data = 16'hCAFE;
    bus.wr_be   = 2'b11;
    tick();
    chk("abort_t1_ctrl", 32'(ctrl()), 32'(C_WR3_AK));
    chk("abort_t1_addr", 32'(bus.mem_addr), 32'h01234);
    bus.wr_req = 1'b0;
    tick();
    chk("abort_t2_ctrl", 32'(ctrl()), 32'(C_WR3));
    reset = 1'b1;
    tick();
    chk("abort_rst_ctrl", 32'(ctrl()), 32'(C_IDLE));
    chk("abort_rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("abort_rst_dout", 32'(bus.mem_dout), 32'h0);
    chk("abort_rst_rd_data", 32'(bus.rd_data), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_after_ctrl", 32'(ctrl()), 32'(C_IDLE));
    end

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
